bus_byte_master: RTL and testbench

- Byte-stream-to-register-bus master: parses read/write commands from a byte stream (host UART/USB FIFO side) and issues single-word transactions on the register bus.
- Slaves such as split/plain bus registers sit downstream; their OR-combined ack/read-data return here.
- Returns a status byte (plus read data) as a byte stream.
- Top level packs the discrete bus outputs into the bus_in bundle and unpacks bus_out.

---
 rtl/bus_byte_master.sv | 200 ++++++++++++++++++++
 tb/tb_bus_byte_master.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_byte_master.sv
// bus_byte_master: turns a host byte stream of read/write commands into
// single-word register-bus transactions and streams back a status byte,
// followed by four data bytes for reads.
//
// Handshakes: a byte moves on in_valid && in_ready, or on out_valid && out_ready.
// Once out_valid is raised, out_valid and out_data hold until the byte is accepted.
module bus_byte_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  bus_clk,
    input  logic                  bus_reset_l,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [31:0]           bus_wr_data,
    output logic                  bus_re,
    output logic                  bus_we,
    input  logic [31:0]           bus_rd_data,
    input  logic                  bus_rd_ack,
    input  logic                  bus_wr_ack,
    output logic                  busy,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_CMD  = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_BUS  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic                    rdy_en_q;
    logic                    is_wr_q, is_wr_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    re_q, re_d;
    logic                    we_q, we_d;
    logic [15:0]             timer_q, timer_d;
    logic [39:0]             resp_q, resp_d;
    logic [2:0]              left_q, left_d;
    logic                    ov_q, ov_d;

    logic in_acc;
    logic out_acc;
    logic ack_hit;

    // in_ready is held low through reset and comes up on the first edge after release
    assign in_ready    = rdy_en_q && (state_q == S_CMD || state_q == S_ADDR || state_q == S_DATA);
    assign in_acc      = in_valid && in_ready;
    assign out_acc     = ov_q && out_ready;
    // only the ack that matches the active strobe counts
    assign ack_hit     = (re_q && bus_rd_ack) || (we_q && bus_wr_ack);

    assign out_data    = resp_q[39:32];
    assign out_valid   = ov_q;
    assign bus_addr    = addr_q;
    assign bus_wr_data = wdata_q;
    assign bus_re      = re_q;
    assign bus_we      = we_q;
    assign busy        = (state_q != S_CMD);
    assign dbg_state   = state_q;

    // Next-state and datapath logic for the command parser / bus sequencer
    always_comb begin
        state_d = state_q;
        is_wr_d = is_wr_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        re_d    = re_q;
        we_d    = we_q;
        timer_d = timer_q;
        resp_d  = resp_q;
        left_d  = left_q;
        ov_d    = ov_q;

        case (state_q)
            S_CMD: begin
                if (in_acc) begin
                    cnt_d = 2'd0;
                    if (in_data == 8'h57) begin
                        is_wr_d = 1'b1;
                        state_d = S_ADDR;
                    end else if (in_data == 8'h52) begin
                        is_wr_d = 1'b0;
                        state_d = S_ADDR;
                    end else begin
                        // unknown opcode: swallow it and report a single 0x02
                        resp_d  = {8'h02, 32'h0};
                        left_d  = 3'd1;
                        ov_d    = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                if (in_acc) begin
                    // shift in MSB first; bytes beyond ADDR_WIDTH fall off the top
                    addr_d = ADDR_WIDTH'({addr_q, in_data});
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (is_wr_q) begin
                            state_d = S_DATA;
                        end else begin
                            state_d = S_BUS;
                            re_d    = 1'b1;
                            timer_d = 16'd0;
                        end
                    end
                end
            end
            S_DATA: begin
                if (in_acc) begin
                    wdata_d = {wdata_q[23:0], in_data};
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_BUS;
                        we_d    = 1'b1;
                        timer_d = 16'd0;
                    end
                end
            end
            S_BUS: begin
                if (ack_hit) begin
                    re_d    = 1'b0;
                    we_d    = 1'b0;
                    resp_d  = {8'h00, (re_q ? bus_rd_data : 32'h0)};
                    left_d  = re_q ? 3'd5 : 3'd1;
                    ov_d    = 1'b1;
                    state_d = S_RESP;
                end else if (timer_q == TMO_LAST) begin
                    // no slave answered: give up and report zeros
                    re_d    = 1'b0;
                    we_d    = 1'b0;
                    resp_d  = {8'h01, 32'h0};
                    left_d  = re_q ? 3'd5 : 3'd1;
                    ov_d    = 1'b1;
                    state_d = S_RESP;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            S_RESP: begin
                if (out_acc) begin
                    resp_d = {resp_q[31:0], 8'h00};
                    left_d = left_q - 3'd1;
                    if (left_q == 3'd1) begin
                        ov_d    = 1'b0;
                        state_d = S_CMD;
                    end
                end
            end
            default: begin
                state_d = S_CMD;
            end
        endcase
    end

    // State and datapath registers; reset abandons any command in flight
    always_ff @(posedge bus_clk or negedge bus_reset_l) begin
        if (!bus_reset_l) begin
            state_q  <= S_CMD;
            rdy_en_q <= 1'b0;
            is_wr_q  <= 1'b0;
            cnt_q    <= 2'd0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            re_q     <= 1'b0;
            we_q     <= 1'b0;
            timer_q  <= 16'd0;
            resp_q   <= 40'h0;
            left_q   <= 3'd0;
            ov_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
            is_wr_q  <= is_wr_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            re_q     <= re_d;
            we_q     <= we_d;
            timer_q  <= timer_d;
            resp_q   <= resp_d;
            left_q   <= left_d;
            ov_q     <= ov_d;
        end
    end

endmodule

// File: tb/tb_bus_byte_master.sv
// Bench for bus_byte_master: directed commands, a small slave model and a
// response-byte scoreboard checked by an independent monitor.
module tb_bus_byte_master;

    localparam int AW  = 16;
    localparam int TMO = 8;

    logic          clk;
    logic          rst_n;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] bus_addr;
    logic [31:0]   bus_wr_data;
    logic          bus_re;
    logic          bus_we;
    logic [31:0]   bus_rd_data;
    logic          bus_rd_ack;
    logic          bus_wr_ack;
    logic          busy;
    logic [2:0]    dbg_state;

    bus_byte_master #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
        .bus_clk     (clk),
        .bus_reset_l (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .bus_re      (bus_re),
        .bus_we      (bus_we),
        .bus_rd_data (bus_rd_data),
        .bus_rd_ack  (bus_rd_ack),
        .bus_wr_ack  (bus_wr_ack),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // slave model: mode 0 acks same cycle, mode 1 acks reads on the 3rd
    // strobe cycle (and raises a bogus wr_ack meanwhile), mode 2 never acks
    int          mode   = 0;
    logic [31:0] rd_val = 32'h0;
    int          re_run = 0;
    always @(posedge clk) re_run <= bus_re ? re_run + 1 : 0;

    assign bus_wr_ack  = (bus_we && mode == 0) || (bus_re && mode == 1);
    assign bus_rd_ack  = bus_re && ((mode == 0) || (mode == 1 && re_run == 2));
    assign bus_rd_data = bus_rd_ack ? rd_val : 32'h0;

    // sink backpressure
    bit bp = 1'b0;
    initial out_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        out_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // scoreboard state
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout expected=event", nm);
    endtask

    // monitor: bus activity counters, response-byte scoreboard, stall stability
    int          re_cyc = 0;
    int          we_cyc = 0;
    logic [31:0] seen_addr  = 32'h0;
    logic [31:0] seen_wdata = 32'h0;
    int          first_ov_cyc = 0;
    logic        prev_ov = 1'b0;
    logic        stall_q = 1'b0;
    logic [7:0]  stall_data = 8'h0;

    always @(negedge clk) begin
        if (bus_re) begin
            re_cyc++;
            seen_addr = 32'(bus_addr);
        end
        if (bus_we) begin
            we_cyc++;
            seen_addr  = 32'(bus_addr);
            seen_wdata = bus_wr_data;
        end
        if (out_valid && !prev_ov) first_ov_cyc = cyc;
        if (stall_q && rst_n) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(stall_data));
        end
        if (out_valid) check("in_ready_during_resp", 32'(in_ready), 32'd0);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte actual=%h expected=none", out_data);
            end else begin
                check("resp_byte", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
        stall_q    = rst_n && out_valid && !out_ready;
        stall_data = out_data;
        prev_ov    = out_valid;
    end

    // driver tasks
    int last_acc = 0;

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail("in_ready_wait");
        last_acc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_write(input logic [31:0] a, input logic [31:0] d, input int gmax);
        logic [7:0] b[9];
        b[0] = 8'h57;
        for (int i = 0; i < 4; i++) b[1+i] = a[31-8*i -: 8];
        for (int i = 0; i < 4; i++) b[5+i] = d[31-8*i -: 8];
        for (int i = 0; i < 9; i++) send_byte(b[i], $urandom_range(0, gmax));
    endtask

    task automatic send_read(input logic [31:0] a, input int gmax);
        logic [7:0] b[5];
        b[0] = 8'h52;
        for (int i = 0; i < 4; i++) b[1+i] = a[31-8*i -: 8];
        for (int i = 0; i < 5; i++) send_byte(b[i], $urandom_range(0, gmax));
    endtask

    task automatic push_read_resp(input logic [7:0] st, input logic [31:0] d);
        exp_q.push_back(st);
        for (int i = 0; i < 4; i++) exp_q.push_back(d[31-8*i -: 8]);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) fail("wait_done");
        @(negedge clk);
    endtask

    task automatic clear_stats();
        re_cyc = 0;
        we_cyc = 0;
        seen_addr  = 32'h0;
        seen_wdata = 32'h0;
    endtask

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    // main sequence
    logic [31:0] rd_tab[3];
    logic [31:0] ad_tab[3];
    initial begin
        rd_tab[0] = 32'hA5C30F96; ad_tab[0] = 32'h5A5A0013;
        rd_tab[1] = 32'h00FF7E01; ad_tab[1] = 32'h00007FFE;
        rd_tab[2] = 32'h80000001; ad_tab[2] = 32'hFFFF0101;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_bus_re", 32'(bus_re), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_addr", 32'(bus_addr), 32'd0);
        check("rst_bus_wr_data", bus_wr_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        // write with same-cycle ack
        mode = 0;
        clear_stats();
        exp_q.push_back(8'h00);
        send_write(32'h00000010, 32'hDEADBEEF, 0);
        wait_done();
        check("w1_we_cycles", 32'(we_cyc), 32'd1);
        check("w1_re_cycles", 32'(re_cyc), 32'd0);
        check("w1_addr", seen_addr, 32'h10);
        check("w1_wdata", seen_wdata, 32'hDEADBEEF);
        check("w1_latency", 32'(first_ov_cyc - last_acc), 32'd2);

        // read acked on the third strobe cycle, bogus wr_ack ignored
        mode = 1;
        rd_val = 32'h12345678;
        clear_stats();
        push_read_resp(8'h00, 32'h12345678);
        send_read(32'h00000010, 0);
        wait_done();
        check("r1_re_cycles", 32'(re_cyc), 32'd3);
        check("r1_we_cycles", 32'(we_cyc), 32'd0);
        check("r1_addr", seen_addr, 32'h10);

        // read with no slave: timeout, upper address bytes dropped
        mode = 2;
        clear_stats();
        push_read_resp(8'h01, 32'h0);
        send_read(32'hABCD1236, 0);
        wait_done();
        check("to_re_cycles", 32'(re_cyc), 32'd8);
        check("to_addr", seen_addr, 32'h1236);

        // bad opcode, then a normal write
        mode = 0;
        clear_stats();
        exp_q.push_back(8'h02);
        send_byte(8'h41, 0);
        exp_q.push_back(8'h00);
        send_write(32'h00000024, 32'h0BADF00D, 0);
        wait_done();
        check("bad_op_we_cycles", 32'(we_cyc), 32'd1);
        check("bad_op_addr", seen_addr, 32'h24);
        check("bad_op_wdata", seen_wdata, 32'h0BADF00D);

        // input gaps and output backpressure on reads
        bp = 1'b1;
        mode = 1;
        for (int k = 0; k < 3; k++) begin
            clear_stats();
            rd_val = rd_tab[k];
            push_read_resp(8'h00, rd_tab[k]);
            send_read(ad_tab[k], 3);
            wait_done();
            check("bp_re_cycles", 32'(re_cyc), 32'd3);
            check("bp_addr", seen_addr, {16'h0, ad_tab[k][15:0]});
        end
        bp = 1'b0;

        // reset in the middle of the address phase
        mode = 0;
        send_byte(8'h57, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_addr_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_addr_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // reset while bus_we is held waiting for an ack
        mode = 2;
        send_write(32'h00000030, 32'h11111111, 0);
        begin
            int n;
            n = 0;
            while (!bus_we && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("we_before_rst", 32'(bus_we), 32'd1);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("we_rst_bus_we", 32'(bus_we), 32'd0);
        check("we_rst_bus_addr", 32'(bus_addr), 32'd0);
        check("we_rst_wr_data", bus_wr_data, 32'd0);
        check("we_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("no_resp_after_rst", 32'(exp_q.size()), 32'd0);

        // full write after reset
        mode = 0;
        clear_stats();
        exp_q.push_back(8'h00);
        send_write(32'h00000044, 32'hCAFEF00D, 0);
        wait_done();
        check("post_rst_we_cycles", 32'(we_cyc), 32'd1);
        check("post_rst_addr", seen_addr, 32'h44);
        check("post_rst_wdata", seen_wdata, 32'hCAFEF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
